// File: rtl/sha256_msg_sched_pkg.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched_pkg
// Shared types, sizes and helper functions for the SHA-256 message-schedule
// controller.
//   word_t            : 32-bit schedule word
//   state_t           : controller state encoding (exposed on the debug port)
//   small_sigma0/1    : SHA-256 message-schedule mixing functions
// -----------------------------------------------------------------------------
package sha256_msg_sched_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int ROUNDS     = 64;
    localparam int DEPTH      = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;

    // IDLE doubles as the load state: words are accepted while in IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        R16  = 3'd2,
        R15  = 3'd3,
        R7   = 3'd4,
        R2   = 3'd5,
        OUT  = 3'd6,
        DONE = 3'd7
    } state_t;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched_if
// Bundles the block-input handshake, the schedule-output handshake, the status
// flags and the controller state debug view.
//   in_valid/in_ready/in_word         : message word input (W0 first)
//   w_valid/w_ready/w_word/w_idx      : schedule word output W[t], t = w_idx
//   busy, done                        : block in progress / block finished pulse
//   dbg_state                         : current controller state
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and its data
// stable until that edge; ready may change freely.
// Modports: slave = the schedule controller, master = the environment.
// -----------------------------------------------------------------------------
interface sha256_msg_sched_if;
    import sha256_msg_sched_pkg::*;

    logic       in_valid;
    logic       in_ready;
    word_t      in_word;
    logic       w_valid;
    logic       w_ready;
    word_t      w_word;
    logic [5:0] w_idx;
    logic       busy;
    logic       done;
    state_t     dbg_state;

    modport slave (
        input  in_valid, in_word, w_ready,
        output in_ready, w_valid, w_word, w_idx, busy, done, dbg_state
    );

    modport master (
        output in_valid, in_word, w_ready,
        input  in_ready, w_valid, w_word, w_idx, busy, done, dbg_state
    );

endinterface

// File: rtl/sha256_msg_sched_ram.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched_ram
// Single-read-port, single-write-port register file.
//   clk   : write clock; the write lands on the falling edge
//   wen   : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// Writing on the falling edge lets a value written during a cycle be read
// combinationally in any later cycle without a bypass path.
// Contents are not reset.
// -----------------------------------------------------------------------------
module sha256_msg_sched_ram #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 16,
    parameter int AW         = $clog2(NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [AW-1:0]         waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [NUM_WORDS];

    always_ff @(negedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched
// SHA-256 message-schedule controller. Loads the 16 words of a 512-bit block
// into a 16-entry circular ram, then emits W[0..63] in order. W[16..63] are
// built with one ram read per cycle:
//   W[t] = W[t-16] + sigma0(W[t-15]) + W[t-7] + sigma1(W[t-2])
// and written back over slot t mod 16 once the word is accepted.
// Ports:
//   clk        : clock
//   rst        : synchronous, active-high reset
//   bus        : sha256_msg_sched_if.slave (input / output handshakes, status)
//   stall_cnt  : [15:0] saturating count of cycles with w_valid && !w_ready,
//                cleared at the first accepted word of each block; present
//                only when SHA256_MSG_SCHED_STALL_CNT_EN is defined
// Timing with w_ready held high: 2 cycles per word for t<16 (RD, OUT),
// 5 cycles per word for t>=16 (R16, R15, R7, R2, OUT).
// -----------------------------------------------------------------------------
module sha256_msg_sched
    import sha256_msg_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    sha256_msg_sched_if.slave    bus
`ifdef SHA256_MSG_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    state_t     state_q, state_d;
    logic [5:0] t_q, t_d;
    logic [3:0] cnt_q, cnt_d;
    word_t      acc_q, acc_d;

    logic       wen;
    logic [3:0] waddr;
    word_t      wdata;
    logic [3:0] raddr;
    word_t      rdata;

    sha256_msg_sched_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .NUM_WORDS  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .wen   (wen && !rst),   // a reset cycle never writes the ram
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Read order R16, R15, R7, R2 means slot t mod 16 (holding W[t-16]) is
    // consumed first and only overwritten later, in OUT.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        raddr   = t_q[3:0];
        wen     = 1'b0;
        waddr   = cnt_q;
        wdata   = bus.in_word;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    wen   = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = RD;
                        t_d     = '0;
                    end
                end
            end
            RD: begin
                acc_d   = rdata;
                state_d = OUT;
            end
            R16: begin
                acc_d   = rdata;
                state_d = R15;
            end
            R15: begin
                raddr   = t_q[3:0] + 4'd1;       // t-15 mod 16
                acc_d   = acc_q + small_sigma0(rdata);
                state_d = R7;
            end
            R7: begin
                raddr   = t_q[3:0] + 4'd9;       // t-7 mod 16
                acc_d   = acc_q + rdata;
                state_d = R2;
            end
            R2: begin
                raddr   = t_q[3:0] - 4'd2;       // t-2 mod 16
                acc_d   = acc_q + small_sigma1(rdata);
                state_d = OUT;
            end
            OUT: begin
                if (bus.w_ready) begin
                    // Slots for t<16 already hold W[t] from the load.
                    if (t_q >= 6'd16) begin
                        wen   = 1'b1;
                        waddr = t_q[3:0];
                        wdata = acc_q;
                    end
                    if (t_q == 6'd63) begin
                        state_d = DONE;
                    end else begin
                        t_d     = t_q + 6'd1;
                        state_d = (t_q < 6'd15) ? RD : R16;
                    end
                end
            end
            DONE: begin
                t_d     = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.w_valid   = (state_q == OUT);
    assign bus.w_word    = acc_q;
    assign bus.w_idx     = t_q;
    assign bus.done      = (state_q == DONE);
    // In IDLE, a non-zero load count means the block has started.
    assign bus.busy      = (state_q == IDLE) ? (cnt_q != 4'd0)
                                             : (state_q != DONE);
    assign bus.dbg_state = state_q;

`ifdef SHA256_MSG_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state_q == IDLE && bus.in_valid && cnt_q == 4'd0) begin
            stall_cnt <= '0;
        end else if (state_q == OUT && !bus.w_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_msg_sched_if bus();

`ifdef SHA256_MSG_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
  sha256_msg_sched dut (.clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt));
`else
  sha256_msg_sched dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] blk_buf [16];
  logic [31:0] exp_w [64];
  logic [31:0] cap_w [64];

  // ---------------- golden model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void build_model();
    for (int i = 0; i < 64; i++) begin
      if (i < 16) exp_w[i] = blk_buf[i];
      else exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
                      + exp_w[i-7]
                      + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
                      + exp_w[i-16];
    end
  endfunction

  function automatic void set_abc();
    for (int i = 0; i < 16; i++) blk_buf[i] = 32'h0;
    blk_buf[0]  = 32'h61626380;
    blk_buf[15] = 32'h00000018;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_block(input int gaps);
    int i = 0;
    int cyc = 0;
    while (i < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (gaps != 0 && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_word  = $urandom;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_word  = blk_buf[i];
        vectors++;
        if (bus.in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL load_in_ready: word %0d got %b want 1", i, bus.in_ready);
        end
        vectors++;
        if (bus.busy !== (i != 0)) begin
          miscompares++;
          $display("FAIL load_busy: word %0d got %b want %0d", i, bus.busy, (i != 0));
        end
        i++;
      end
    end
    if (i < 16) begin
      miscompares++;
      $display("FAIL load_timeout: accepted %0d want 16", i);
    end
  endtask

  // mode 0: w_ready high; 1: random w_ready; 2: stall 7 cycles at the first word.
  // stop_idx >= 0: assert rst when W[stop_idx] is presented and return.
  task automatic collect(input int mode, input int garbage, input int stop_idx,
                         output int last_cycle);
    int got = 0;
    int cyc = 0;
    int stalls = 0;
    int stopped = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [31:0] pw = '0;
    logic [5:0] pi = '0;
    logic rdy;
    last_cycle = -1;
    while (got < 64 && cyc < 3000 && stopped == 0) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = (garbage != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_word  = $urandom;
      if (cyc == 1) begin
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.w_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL first_cycle: in_ready %b w_valid %b want 0 0", bus.in_ready, bus.w_valid);
        end
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else begin
        rdy = !(bus.w_valid && stalls < 7);
`ifdef SHA256_MSG_SCHED_STALL_CNT_EN
        if (bus.w_valid && stalls == 7) begin
          stalls++;
          vectors++;
          if (stall_cnt !== 16'd7) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d want 7", stall_cnt);
          end
        end
`endif
      end
      bus.w_ready = rdy;
      if (bus.w_valid && !rdy) stalls++;
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL status_mid: done %b busy %b want 0 1", bus.done, bus.busy);
      end
      if (pv && !pr) begin
        vectors++;
        if (bus.w_valid !== 1'b1 || bus.w_word !== pw || bus.w_idx !== pi) begin
          miscompares++;
          $display("FAIL stall_hold: got v%b %h idx %0d want v1 %h idx %0d",
                   bus.w_valid, bus.w_word, bus.w_idx, pw, pi);
        end
      end
      if (bus.w_valid) begin
        vectors++;
        if (bus.w_idx !== 6'(got) || bus.w_word !== exp_w[got]) begin
          miscompares++;
          $display("FAIL w_word: got %h idx %0d want %h idx %0d",
                   bus.w_word, bus.w_idx, exp_w[got], got);
        end
        cap_w[got] = bus.w_word;
        if (stop_idx >= 0 && got == stop_idx) begin
          rst = 1'b1;
          stopped = 1;
        end
      end
      if (stopped == 0 && bus.w_valid && rdy) begin
        got++;
        if (got == 64) last_cycle = cyc;
      end
      pv = bus.w_valid; pr = rdy; pw = bus.w_word; pi = bus.w_idx;
    end
    if (stopped == 0) begin
      if (got < 64) begin
        miscompares++;
        $display("FAIL collect_timeout: got %0d words want 64", got);
      end else begin
        @(negedge clk);
        bus.w_ready = 1'b0;
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL done_pulse: done %b busy %b want 1 0", bus.done, bus.busy);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL after_done: done %b in_ready %b busy %b want 0 1 0",
                   bus.done, bus.in_ready, bus.busy);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_word = '0; bus.w_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.w_idx !== 6'd0 ||
        bus.w_word !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: rdy %b v %b idx %0d word %h busy %b done %b want 1 0 0 0 0 0",
               bus.in_ready, bus.w_valid, bus.w_idx, bus.w_word, bus.busy, bus.done);
    end
`ifdef SHA256_MSG_SCHED_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_abc();
    int lc;
    set_abc();
    build_model();
    load_block(0);
    collect(0, 0, -1, lc);
    vectors++;
    if (cap_w[16] !== 32'h61626380) begin
      miscompares++;
      $display("FAIL abc_w16: got %h want 61626380", cap_w[16]);
    end
    vectors++;
    if (cap_w[17] !== 32'h000F0000) begin
      miscompares++;
      $display("FAIL abc_w17: got %h want 000f0000", cap_w[17]);
    end
  endtask

  task automatic test_zero_latency();
    int lc;
    for (int i = 0; i < 16; i++) blk_buf[i] = 32'h0;
    build_model();
    load_block(0);
    collect(0, 0, -1, lc);
    vectors++;
    if (lc != 272) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d cycles want 272", lc);
    end
  endtask

  task automatic test_load_toggle();
    int lc;
    for (int i = 0; i < 16; i++) blk_buf[i] = $urandom;
    build_model();
    load_block(1);
    collect(0, 1, -1, lc);   // in_valid keeps toggling with junk during emit
  endtask

  task automatic test_backpressure();
    int lc;
    for (int b = 0; b < 100; b++) begin
      for (int i = 0; i < 16; i++) blk_buf[i] = $urandom;
      build_model();
      load_block(b % 2);
      collect(1, 0, -1, lc);
    end
  endtask

  task automatic test_reset_mid();
    int lc;
    set_abc();
    build_model();
    load_block(0);
    collect(0, 0, 20, lc);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.w_idx !== 6'd0) begin
      miscompares++;
      $display("FAIL mid_reset: rdy %b v %b busy %b idx %0d want 1 0 0 0",
               bus.in_ready, bus.w_valid, bus.busy, bus.w_idx);
    end
    load_block(0);
    collect(0, 0, -1, lc);
  endtask

  task automatic test_stall_cnt();
    int lc;
    for (int i = 0; i < 16; i++) blk_buf[i] = $urandom;
    build_model();
    load_block(0);
    collect(2, 0, -1, lc);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero_latency();
    test_load_toggle();
    test_backpressure();
    test_reset_mid();
    test_stall_cnt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
